// File: rtl/dab_phase_shift_modulator.sv
// Phase-shift carrier modulator for a dual-active-bridge: one primary and NCH secondary
// full bridges with per-gate dead-time insertion, ADC trigger and a small run/fault FSM.
module dab_phase_shift_modulator #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned NCH   = 2,
  parameter int unsigned DT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 CE,
  input  logic                 sync,
  input  logic                 enable,
  input  logic                 flt,
  input  logic [CNT_W-1:0]     period,
  input  logic [NCH*CNT_W-1:0] phase,
  input  logic [DT_W-1:0]      deadtime,
  output logic [3:0]           Sp,
  output logic [4*NCH-1:0]     Ss,
  output logic                 trigger,
  output logic [1:0]           modo
);

  localparam int unsigned NG = 4 + 4 * NCH;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StArm   = 2'b01,
    StRun   = 2'b10,
    StFault = 2'b11
  } state_e;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [CNT_W-1:0]            per_q, per_d;
  logic [NCH*CNT_W-1:0]        ph_q, ph_d;
  logic [DT_W-1:0]             dt_q, dt_d;
  logic                        sync_q;
  logic [NG-1:0]               gate_q, gate_d;
  logic [NG-1:0][DT_W-1:0]     tmr_q, tmr_d;
  logic                        trig_q, trig_d;

  logic [CNT_W-1:0] p_eff, h_eff;
  logic             sync_rise, at_end, run_keep;
  logic             a_raw;
  logic [NCH-1:0]   b_raw;
  logic [NG-1:0]    raw;

  assign p_eff     = (per_q < CNT_W'(4)) ? CNT_W'(4) : per_q;
  assign h_eff     = p_eff >> 1;
  assign sync_rise = sync & ~sync_q;
  assign at_end    = (cnt_q >= p_eff - 1'b1);
  assign a_raw     = (cnt_q < h_eff);
  assign raw[3:0]  = {a_raw, ~a_raw, ~a_raw, a_raw};

  // Secondary carrier is the primary count shifted back by the clamped phase, modulo P.
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [CNT_W-1:0] ph_k, ph_c, ck;
    logic [CNT_W:0]   diff;
    assign ph_k     = ph_q[k*CNT_W +: CNT_W];
    assign ph_c     = (ph_k > h_eff) ? h_eff : ph_k;
    assign diff     = {1'b0, cnt_q} - {1'b0, ph_c};
    assign ck       = diff[CNT_W] ? diff[CNT_W-1:0] + p_eff : diff[CNT_W-1:0];
    assign b_raw[k] = (ck < h_eff);
    assign raw[4*k+4 +: 4] = {b_raw[k], ~b_raw[k], ~b_raw[k], b_raw[k]};
  end

  always_comb begin
    state_d = state_q;
    if (flt) begin
      state_d = StFault;
    end else if (CE) begin
      unique case (state_q)
        StIdle:  if (enable) state_d = StArm;
        StArm:   if (!enable) state_d = StIdle;
                 else if (sync_rise) state_d = StRun;
        StRun:   if ((at_end || sync_rise) && !enable) state_d = StIdle;
        StFault: if (!enable) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  assign run_keep = (state_q == StRun) && (state_d == StRun);

  always_comb begin
    cnt_d = cnt_q;
    if (!run_keep) begin
      cnt_d = '0;
    end else if (CE) begin
      cnt_d = (sync_rise || at_end) ? '0 : cnt_q + 1'b1;
    end
  end

  // Shadows track the inputs while stopped and only take new values at the period boundary.
  always_comb begin
    per_d = per_q;
    ph_d  = ph_q;
    dt_d  = dt_q;
    if ((state_q == StIdle) || (state_q == StArm) || ((state_q == StRun) && CE && at_end)) begin
      per_d = period;
      ph_d  = phase;
      dt_d  = deadtime;
    end
  end

  // A gate rises only after its raw wave has been high for deadtime+1 consecutive CE cycles.
  always_comb begin
    gate_d = gate_q;
    tmr_d  = tmr_q;
    if (!run_keep) begin
      gate_d = '0;
      tmr_d  = '0;
    end else if (CE) begin
      for (int i = 0; i < NG; i++) begin
        if (!raw[i]) begin
          gate_d[i] = 1'b0;
          tmr_d[i]  = '0;
        end else if (!gate_q[i]) begin
          if (tmr_q[i] >= dt_q) gate_d[i] = 1'b1;
          else                  tmr_d[i]  = tmr_q[i] + 1'b1;
        end
      end
    end
  end

  assign trig_d = run_keep && CE && ((cnt_q == '0) || (cnt_q == h_eff));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      per_q   <= '0;
      ph_q    <= '0;
      dt_q    <= '0;
      sync_q  <= 1'b0;
      gate_q  <= '0;
      tmr_q   <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      ph_q    <= ph_d;
      dt_q    <= dt_d;
      sync_q  <= sync;
      gate_q  <= gate_d;
      tmr_q   <= tmr_d;
      trig_q  <= trig_d;
    end
  end

  assign Sp      = gate_q[3:0];
  assign Ss      = gate_q[NG-1:4];
  assign trigger = trig_q;
  assign modo    = state_q;

endmodule

// File: tb/tb_dab_phase_shift_modulator.sv
// Bench for dab_phase_shift_modulator: a cycle-level behavioural model checked every cycle,
// plus hand-computed waveform points for each directed scenario.
module tb_dab_phase_shift_modulator;
  localparam int CW = 16;
  localparam int NC = 2;
  localparam int DW = 8;
  localparam int NG = 4 + 4 * NC;

  logic clk = 1'b0;
  logic rst, ce, sync, enable, flt;
  logic [CW-1:0]    period;
  logic [NC*CW-1:0] phase;
  logic [DW-1:0]    deadtime;
  logic [3:0]       Sp;
  logic [4*NC-1:0]  Ss;
  logic             trigger;
  logic [1:0]       modo;

  int tests = 0;
  int fails = 0;

  dab_phase_shift_modulator #(.CNT_W(CW), .NCH(NC), .DT_W(DW)) dut (
    .clk(clk), .rst(rst), .CE(ce), .sync(sync), .enable(enable), .flt(flt),
    .period(period), .phase(phase), .deadtime(deadtime),
    .Sp(Sp), .Ss(Ss), .trigger(trigger), .modo(modo)
  );

  always #5 clk = ~clk;

  // Model state: mode 0 idle, 1 arm, 2 run, 3 fault.
  int m_mode, m_cnt, m_p, m_h, m_dt;
  int m_ph[NC];
  int m_len[NG];
  bit m_sync_prev;
  logic [NG-1:0] exp_g;
  logic exp_trig;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_p = 4; m_h = 2; m_dt = 0; m_sync_prev = 0;
    exp_g = '0; exp_trig = 1'b0;
    for (int k = 0; k < NC; k++) m_ph[k] = 0;
    for (int i = 0; i < NG; i++) m_len[i] = 0;
  endtask

  task automatic model_step();
    bit srise, at_end, keep, a, b;
    int nmode, ck, pk;
    logic [NG-1:0] rw;
    srise  = sync && !m_sync_prev;
    at_end = (m_cnt == m_p - 1);
    nmode  = m_mode;
    if (flt) nmode = 3;
    else if (ce) begin
      case (m_mode)
        0: if (enable) nmode = 1;
        1: if (!enable) nmode = 0; else if (srise) nmode = 2;
        2: if ((at_end || srise) && !enable) nmode = 0;
        default: if (!enable) nmode = 0;
      endcase
    end
    keep = (m_mode == 2) && (nmode == 2);
    a = (m_cnt < m_h);
    rw[0] = a; rw[1] = !a; rw[2] = !a; rw[3] = a;
    for (int k = 0; k < NC; k++) begin
      ck = (m_cnt - m_ph[k] + m_p) % m_p;
      b = (ck < m_h);
      rw[4*k+4] = b; rw[4*k+5] = !b; rw[4*k+6] = !b; rw[4*k+7] = b;
    end
    if (!keep) begin
      exp_g = '0; exp_trig = 1'b0;
      for (int i = 0; i < NG; i++) m_len[i] = 0;
    end else if (ce) begin
      for (int i = 0; i < NG; i++) begin
        m_len[i] = rw[i] ? m_len[i] + 1 : 0;
        exp_g[i] = (m_len[i] > m_dt);
      end
      exp_trig = (m_cnt == 0) || (m_cnt == m_h);
    end else begin
      exp_trig = 1'b0;
    end
    if (m_mode <= 1 || (m_mode == 2 && ce && at_end)) begin
      m_p  = (int'(period) < 4) ? 4 : int'(period);
      m_h  = m_p / 2;
      m_dt = int'(deadtime);
      for (int k = 0; k < NC; k++) begin
        pk = int'(phase[k*CW +: CW]);
        m_ph[k] = (pk > m_h) ? m_h : pk;
      end
    end
    if (!keep) m_cnt = 0;
    else if (ce) m_cnt = (srise || at_end) ? 0 : m_cnt + 1;
    m_mode = nmode;
    m_sync_prev = sync;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  // Every-cycle compare against the model, plus the no-shoot-through check on all pairs.
  initial begin
    logic [2*NC+1:0] ovl;
    forever begin
      @(negedge clk);
      ovl[0] = Sp[0] & Sp[1];
      ovl[1] = Sp[2] & Sp[3];
      for (int k = 0; k < NC; k++) begin
        ovl[2*k+2] = Ss[4*k] & Ss[4*k+1];
        ovl[2*k+3] = Ss[4*k+2] & Ss[4*k+3];
      end
      chk("pair_overlap", 32'(ovl), 32'd0);
      if (rst) begin
        chk("modo", 32'(modo), 32'(m_mode));
        chk("Sp", 32'(Sp), 32'(exp_g[3:0]));
        chk("Ss", 32'(Ss), 32'(exp_g[NG-1:4]));
        chk("trigger", 32'(trigger), 32'(exp_trig));
      end
    end
  end

  // Advance to the next negedge at which the model counter equals c.
  task automatic goto_cnt(input int c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_cnt != c && n < 400);
    chk("goto_cnt", 32'(m_cnt), 32'(c));
  endtask

  initial begin
    rst = 1'b0; ce = 1'b1; sync = 1'b0; enable = 1'b0; flt = 1'b0;
    period = 16'd100; phase = {16'd0, 16'd25}; deadtime = 8'd5;
    repeat (2) @(negedge clk);
    chk("rst_modo", 32'(modo), 32'd0);
    chk("rst_outs", 32'({Sp, Ss, trigger}), 32'd0);
    rst = 1'b1;
    @(negedge clk); chk("idle_modo", 32'(modo), 32'd0);
    enable = 1'b1;
    @(negedge clk); chk("arm_modo", 32'(modo), 32'd1);
    repeat (3) @(negedge clk);
    chk("arm_wait_sync", 32'(modo), 32'd1);
    sync = 1'b1;
    @(negedge clk); chk("run_modo", 32'(modo), 32'd2);
    sync = 1'b0;

    // Base waveform: P=100, dead time 5, ch0 phase 25, ch1 phase 0.
    goto_cnt(1);  chk("trig_c0", 32'(trigger), 32'd1);
    goto_cnt(2);  chk("trig_off", 32'(trigger), 32'd0);
    goto_cnt(5);  chk("sp_dead", 32'(Sp), 32'h0);
    goto_cnt(6);  chk("sp1_rise", 32'(Sp), 32'h9);
                  chk("ch1_eq_sp", 32'(Ss[7:4]), 32'h9);
    goto_cnt(30); chk("ss0_dead", 32'(Ss[3:0]), 32'h0);
    goto_cnt(31); chk("ss0_rise", 32'(Ss[3:0]), 32'h9);
    goto_cnt(50); chk("sp1_last", 32'(Sp), 32'h9);
    goto_cnt(51); chk("sp_fall", 32'(Sp), 32'h0);
                  chk("trig_half", 32'(trigger), 32'd1);
    goto_cnt(55); chk("sp2_dead", 32'(Sp), 32'h0);
    goto_cnt(56); chk("sp2_rise", 32'(Sp), 32'h6);
    goto_cnt(75); chk("ss0_last", 32'(Ss[3:0]), 32'h9);
    goto_cnt(76); chk("ss0_fall", 32'(Ss[3:0]), 32'h0);

    // Phase change mid-period takes effect only from the next period start.
    goto_cnt(10); phase = {16'd0, 16'd40};
    goto_cnt(31); chk("ph_old_kept", 32'(Ss[3:0]), 32'h9);
    goto_cnt(31); chk("ph_new_low", 32'(Ss[3:0]), 32'h6);
    goto_cnt(45); chk("ph_new_dead", 32'(Ss[3:0]), 32'h0);
    goto_cnt(46); chk("ph_new_rise", 32'(Ss[3:0]), 32'h9);

    // Phase beyond H clamps to H: ch0 follows Sp2 timing.
    phase = {16'd0, 16'd80};
    goto_cnt(0);
    goto_cnt(55); chk("clamp_dead", 32'(Ss[3:0]), 32'h0);
    goto_cnt(56); chk("clamp_ss0", 32'(Ss[3:0]), 32'h9);
                  chk("clamp_sp", 32'(Sp), 32'h6);

    // Clock enable low freezes everything and suppresses the trigger.
    goto_cnt(50); ce = 1'b0;
    @(negedge clk); chk("ce_trig_sup", 32'(trigger), 32'd0);
    repeat (3) @(negedge clk);
    chk("ce_hold_sp", 32'(Sp), 32'h9);
    ce = 1'b1;
    @(negedge clk); chk("ce_resume_trig", 32'(trigger), 32'd1);

    // Sync edge in RUN realigns the carrier.
    goto_cnt(60); sync = 1'b1;
    @(negedge clk);
    @(negedge clk); chk("realign_trig", 32'(trigger), 32'd1);
                    chk("realign_sp", 32'(Sp), 32'h0);
    sync = 1'b0;

    // Stop request completes the current period.
    goto_cnt(20); enable = 1'b0;
    goto_cnt(56); chk("stop_still_sw", 32'(Sp), 32'h6);
    goto_cnt(99); chk("stop_last_run", 32'(modo), 32'd2);
    @(negedge clk); chk("stop_idle", 32'(modo), 32'd0);
                    chk("stop_gates", 32'({Sp, Ss}), 32'd0);

    // Fault handling.
    phase = {16'd0, 16'd25};
    enable = 1'b1; @(negedge clk);
    sync = 1'b1;   @(negedge clk);
    sync = 1'b0;
    goto_cnt(30); flt = 1'b1;
    @(negedge clk); chk("flt_modo", 32'(modo), 32'd3);
                    chk("flt_gates", 32'({Sp, Ss}), 32'd0);
    flt = 1'b0;
    repeat (3) @(negedge clk);
    chk("flt_hold", 32'(modo), 32'd3);
    enable = 1'b0;
    @(negedge clk); chk("flt_exit", 32'(modo), 32'd0);

    // Minimum period: period=2 becomes P=4, H=2, no dead time.
    period = 16'd2; deadtime = 8'd0;
    enable = 1'b1; @(negedge clk);
    sync = 1'b1;   @(negedge clk);
    sync = 1'b0;
    goto_cnt(1); chk("p4_c1", 32'(Sp), 32'h9); chk("p4_t1", 32'(trigger), 32'd1);
    goto_cnt(2); chk("p4_c2", 32'(Sp), 32'h9); chk("p4_t2", 32'(trigger), 32'd0);
    goto_cnt(3); chk("p4_c3", 32'(Sp), 32'h6); chk("p4_t3", 32'(trigger), 32'd1);
    goto_cnt(0); chk("p4_c0", 32'(Sp), 32'h6);

    // Asynchronous reset mid-cycle.
    #2 rst = 1'b0;
    #1 chk("async_rst_outs", 32'({Sp, Ss, trigger}), 32'd0);
       chk("async_rst_modo", 32'(modo), 32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_needs_sync", 32'(modo), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
